// File: rtl/rand_pkg.sv
// Shared types, constants and parameter check for the random target sequencer.
package rand_pkg;

   localparam int unsigned SEQ_LEN = 4;
   localparam int unsigned BYTE_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      PRESENT
   } state_t;

   // NUM_TARGETS must fit the index width, and the index must fit in a byte.
   function automatic bit num_targets_ok(input int unsigned n, input int unsigned idx_w);
      return (n >= 2) && (n <= 16) && (idx_w <= BYTE_W) && (n <= (32'd1 << idx_w));
   endfunction

endpackage

// File: rtl/rand_mod_reducer.sv
// Iterative modulo reducer: subtracts NUM_TARGETS once per step until below it.
module rand_mod_reducer
   import rand_pkg::*;
#(
   parameter int unsigned NUM_TARGETS = 4,
   parameter int unsigned IDX_W       = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic [BYTE_W-1:0] i_load_val,
   input  logic              i_step,
   output logic [IDX_W-1:0]  o_idx_c,
   output logic              o_ready_c
);

   localparam logic [BYTE_W-1:0] N_B = BYTE_W'(NUM_TARGETS);

   logic [BYTE_W-1:0] r_work;

   assign o_ready_c = (r_work < N_B);
   assign o_idx_c   = r_work[IDX_W-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_work <= '0;
      end else if (i_load) begin
         r_work <= i_load_val;
      end else if (i_step && !o_ready_c) begin
         r_work <= r_work - N_B;
      end
   end

endmodule

// File: rtl/rand_target_sequencer.sv
// Snapshots a packed random word, reduces each byte to a target index and
// presents the four indices over valid/ready with back-to-back duplicate suppression.
module rand_target_sequencer
   import rand_pkg::*;
#(
   parameter int unsigned NUM_TARGETS = 4,
   parameter int unsigned IDX_W       = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [SEQ_LEN*BYTE_W-1:0] random_num,
   input  logic                      start,
   output logic [IDX_W-1:0]          target,
   output logic                      target_valid,
   input  logic                      target_ready,
   output logic [1:0]                seq_index,
   output logic                      busy,
   output logic                      done
);

   if (!num_targets_ok(NUM_TARGETS, IDX_W)) begin : g_param_check
      $error("rand_target_sequencer: illegal NUM_TARGETS / IDX_W combination");
   end

   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_TARGETS - 1);
   localparam logic [1:0]       LAST_SEQ = 2'(SEQ_LEN - 1);

   state_t                           r_state;
   logic [SEQ_LEN-1:0][BYTE_W-1:0]   r_snap;
   logic [1:0]                       r_seq;
   logic [IDX_W-1:0]                 r_prev;
   logic [IDX_W-1:0]                 r_target;
   logic                             r_valid;
   logic                             r_busy;
   logic                             r_done;

   logic                             w_load;
   logic [BYTE_W-1:0]                w_load_val;
   logic                             w_step;
   logic [IDX_W-1:0]                 w_idx;
   logic                             w_lt;
   logic                             w_hs;
   logic                             w_accept;
   logic [1:0]                       w_next_seq;
   logic [IDX_W-1:0]                 w_cand;

   rand_mod_reducer #(
      .NUM_TARGETS (NUM_TARGETS),
      .IDX_W       (IDX_W)
   ) u_reducer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_step     (w_step),
      .o_idx_c    (w_idx),
      .o_ready_c  (w_lt)
   );

   // Start is refused during the done cycle even though the FSM is already idle.
   assign w_accept   = start && !r_done;
   assign w_hs       = r_valid && target_ready;
   assign w_next_seq = r_seq + 2'd1;

   // Reducer control and duplicate-adjusted candidate index.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      w_step     = 1'b0;
      w_cand     = w_idx;
      if ((r_seq != 2'd0) && (w_idx == r_prev)) begin
         w_cand = (w_idx == IDX_MAX) ? '0 : w_idx + IDX_W'(1);
      end
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_load     = 1'b1;
               w_load_val = random_num[BYTE_W-1:0];
            end
         end
         REDUCE: begin
            w_step = !w_lt;
         end
         PRESENT: begin
            if (w_hs && (r_seq != LAST_SEQ)) begin
               w_load     = 1'b1;
               w_load_val = r_snap[w_next_seq];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_snap   <= '0;
         r_seq    <= '0;
         r_prev   <= '0;
         r_target <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_snap  <= random_num;
                  r_seq   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= REDUCE;
               end
            end
            REDUCE: begin
               if (w_lt) begin
                  r_target <= w_cand;
                  r_valid  <= 1'b1;
                  r_state  <= PRESENT;
               end
            end
            PRESENT: begin
               if (w_hs) begin
                  r_prev  <= r_target;
                  r_valid <= 1'b0;
                  if (r_seq == LAST_SEQ) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_seq   <= w_next_seq;
                     r_state <= REDUCE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign target       = r_target;
   assign target_valid = r_valid;
   assign seq_index    = r_seq;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_rand_target_sequencer.sv
// Randomized self-checking bench for rand_target_sequencer against a modulo/duplicate model.
`timescale 1ns/1ps
module tb_rand_target_sequencer;

   localparam int NT = 4;
   localparam int IW = 4;
   localparam int MAX_CYC = 400;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          target_ready = 1'b0;
   logic [31:0]   random_num = '0;
   logic [IW-1:0] target;
   logic          target_valid;
   logic [1:0]    seq_index;
   logic          busy;
   logic          done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [IW-1:0] g_tgt [4];
   int g_n, g_lat0, g_stab_err, g_busy_err, g_seq_err, g_done_cnt, g_done_gap;
   logic g_after_done, g_after_busy, g_tmo;
   int exp_tgt [4];
   int exp_lat0;

   always #5 clk = ~clk;

   rand_target_sequencer #(.NUM_TARGETS(NT), .IDX_W(IW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .random_num   (random_num),
      .start        (start),
      .target       (target),
      .target_valid (target_valid),
      .target_ready (target_ready),
      .seq_index    (seq_index),
      .busy         (busy),
      .done         (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: each byte mod N, bumped (with wrap) if equal to the previous presented index.
   function automatic void set_model(input logic [31:0] w);
      int prev;
      int idx;
      int b;
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         b   = int'(w[8*i +: 8]);
         idx = b % NT;
         if (i > 0 && idx == prev) idx = (idx + 1) % NT;
         exp_tgt[i] = idx;
         prev = idx;
      end
      exp_lat0 = int'(w[7:0]) / NT + 1;
   endfunction

   // Drives one full sequence and records what was observed; lowcyc<0 means random ready.
   task automatic run_seq(input logic [31:0] w, input int lowcyc, input bit noise, input bit btb);
      int c;
      int vcnt;
      int hs4;
      logic pv;
      logic rdy;
      logic [IW-1:0] pt;
      c = 0; vcnt = 0; hs4 = -1;
      g_n = 0; g_lat0 = -1; g_stab_err = 0; g_busy_err = 0; g_seq_err = 0;
      g_done_cnt = 0; g_done_gap = -1; g_tmo = 1'b0;
      random_num = w; start = 1'b1; target_ready = (lowcyc == 0);
      tick();
      start = 1'b0;
      while (c < MAX_CYC) begin
         pv = target_valid;
         pt = target;
         if (lowcyc < 0)       rdy = 1'($urandom_range(1));
         else if (lowcyc == 0) rdy = 1'b1;
         else                  rdy = target_valid && (vcnt >= lowcyc);
         target_ready = rdy;
         if (noise) begin
            random_num = $urandom;
            start      = 1'($urandom_range(1));
         end
         tick();
         c++;
         if (pv && rdy) begin
            if (g_n < 4) g_tgt[g_n] = pt;
            g_n++;
            vcnt = 0;
            if (g_n == 4) hs4 = c;
         end else if (pv) begin
            vcnt++;
            if (!target_valid || target !== pt) g_stab_err++;
         end
         if (target_valid && g_lat0 < 0) g_lat0 = c;
         if (done) begin
            g_done_cnt++;
            g_done_gap = c - hs4;
            if (busy !== 1'b0) g_busy_err++;
            break;
         end else begin
            if (busy !== 1'b1) g_busy_err++;
            if (seq_index !== 2'(g_n)) g_seq_err++;
         end
      end
      if (c >= MAX_CYC) g_tmo = 1'b1;
      start = btb;
      random_num = $urandom;
      tick();
      start = 1'b0;
      g_after_done = done;
      g_after_busy = busy | target_valid;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      n_assert++; if (target !== '0)       begin n_fail++; $display("FAIL reset_target got=%0d exp=0", target); end
      n_assert++; if (target_valid !== 0)  begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", target_valid); end
      n_assert++; if (seq_index !== 2'd0)  begin n_fail++; $display("FAIL reset_seq got=%0d exp=0", seq_index); end
      n_assert++; if (busy !== 0)          begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      n_assert++; if (done !== 0)          begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
      @(negedge clk);
      reset_n = 1'b1;
      tick(); tick();
      n_assert++; if (busy !== 0 || target_valid !== 0) begin n_fail++; $display("FAIL reset_release_idle got busy=%0b valid=%0b exp 0/0", busy, target_valid); end
   endtask

   task automatic test_seq_common(input string nm, input logic [31:0] w, input int lowcyc, input bit noise);
      set_model(w);
      run_seq(w, lowcyc, noise, 1'b0);
      n_assert++; if (g_tmo !== 0)      begin n_fail++; $display("FAIL %s_timeout got=%0b exp=0", nm, g_tmo); end
      n_assert++; if (g_n !== 4)        begin n_fail++; $display("FAIL %s_handshakes got=%0d exp=4", nm, g_n); end
      for (int i = 0; i < 4; i++) begin
         n_assert++; if (g_tgt[i] !== IW'(exp_tgt[i])) begin n_fail++; $display("FAIL %s_target%0d got=%0d exp=%0d", nm, i, g_tgt[i], exp_tgt[i]); end
      end
      n_assert++; if (g_lat0 !== exp_lat0) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", nm, g_lat0, exp_lat0); end
      n_assert++; if (g_done_cnt !== 1 || g_done_gap !== 0) begin n_fail++; $display("FAIL %s_done got cnt=%0d gap=%0d exp 1/0", nm, g_done_cnt, g_done_gap); end
      n_assert++; if (g_after_done !== 0 || g_after_busy !== 0) begin n_fail++; $display("FAIL %s_after_done got done=%0b busy|valid=%0b exp 0/0", nm, g_after_done, g_after_busy); end
      n_assert++; if (g_busy_err !== 0 || g_seq_err !== 0) begin n_fail++; $display("FAIL %s_busy_seq got busy_err=%0d seq_err=%0d exp 0/0", nm, g_busy_err, g_seq_err); end
      n_assert++; if (g_stab_err !== 0) begin n_fail++; $display("FAIL %s_stability got=%0d exp=0", nm, g_stab_err); end
   endtask

   task automatic test_basic();
      test_seq_common("basic", 32'h0C070502, 0, 1'b0);
   endtask

   task automatic test_dup_suppress();
      test_seq_common("dup", 32'h03070206, 0, 1'b0);
   endtask

   task automatic test_worst_latency();
      test_seq_common("worst", 32'h000000FF, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      test_seq_common("bp", $urandom, 5, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      logic [31:0] w2;
      int c;
      int hs;
      logic pv;
      w = $urandom & 32'h3F3F3F3F;
      set_model(w);
      random_num = w; start = 1'b1; target_ready = 1'b1;
      tick();
      start = 1'b0;
      c = 0; hs = 0;
      while (hs < 2 && c < MAX_CYC) begin
         pv = target_valid;
         tick(); c++;
         if (pv) hs++;
      end
      target_ready = 1'b0;
      while (!target_valid && c < MAX_CYC) begin tick(); c++; end
      n_assert++; if (c >= MAX_CYC) begin n_fail++; $display("FAIL rmid_timeout got cycles=%0d exp<%0d", c, MAX_CYC); end
      n_assert++; if (target !== IW'(exp_tgt[2])) begin n_fail++; $display("FAIL rmid_third_target got=%0d exp=%0d", target, exp_tgt[2]); end
      #2;
      reset_n = 1'b0;
      #1;
      n_assert++; if (target_valid !== 0 || busy !== 0 || done !== 0) begin n_fail++; $display("FAIL rmid_async_ctrl got valid=%0b busy=%0b done=%0b exp 0", target_valid, busy, done); end
      n_assert++; if (seq_index !== 2'd0 || target !== '0) begin n_fail++; $display("FAIL rmid_async_data got seq=%0d target=%0d exp 0/0", seq_index, target); end
      tick(); tick();
      @(negedge clk);
      reset_n = 1'b1;
      target_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_assert++; if (busy !== 0 || target_valid !== 0 || done !== 0) begin n_fail++; $display("FAIL rmid_idle%0d got busy=%0b valid=%0b done=%0b exp 0", i, busy, target_valid, done); end
      end
      w2 = {$urandom_range(255, 0) == 0 ? 24'h010203 : 24'($urandom), 8'(exp_tgt[1])};
      test_seq_common("rmid_fresh", w2, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      w = $urandom & 32'h1F1F1F1F;
      set_model(w);
      run_seq(w, 0, 1'b0, 1'b1);
      n_assert++; if (g_n !== 4 || g_done_cnt !== 1) begin n_fail++; $display("FAIL b2b_first got hs=%0d done=%0d exp 4/1", g_n, g_done_cnt); end
      n_assert++; if (g_after_busy !== 0) begin n_fail++; $display("FAIL b2b_start_on_done got busy|valid=%0b exp=0", g_after_busy); end
      test_seq_common("b2b_next", $urandom & 32'h7F7F7F7F, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         test_seq_common($sformatf("rand%0d", k), $urandom, -1, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dup_suppress();
      test_worst_latency();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
